// File: rtl/uart_digit_receiver_pkg.sv
// Shared definitions for the UART digit receiver: receiver state encoding,
// the ASCII digit range and the default bit period.
package uart_digit_receiver_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_NINE = 8'h39;

   // 100 MHz system clock, 9600 baud
   localparam int DEFAULT_CLKS_PER_BIT = 10416;

endpackage

// File: rtl/uart_digit_receiver_rx.sv
// 8N1 UART byte receiver, LSB first, sampling each bit at its centre.
// byte_valid / frame_err pulse for one cycle after the stop-bit sample.
module uart_rx_byte
   import uart_digit_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_t     state, state_next;
   logic [CW-1:0] clk_cnt, clk_cnt_next;
   logic [2:0]    bit_idx, bit_idx_next;
   logic [7:0]    shift, shift_next;
   logic          valid_next, ferr_next;
   logic          rxd_meta, rxd_sync;

   // Synchronizer resets to the idle-high line level so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_sync <= rxd_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RX_IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_next;
         clk_cnt    <= clk_cnt_next;
         bit_idx    <= bit_idx_next;
         shift      <= shift_next;
         byte_valid <= valid_next;
         frame_err  <= ferr_next;
      end
   end

   // A start bit still high at its centre is treated as line noise, not an error
   always_comb begin
      state_next   = state;
      clk_cnt_next = clk_cnt + 1'b1;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      valid_next   = 1'b0;
      ferr_next    = 1'b0;
      case (state)
         RX_IDLE: begin
            clk_cnt_next = '0;
            bit_idx_next = '0;
            if (!rxd_sync) state_next = RX_START;
         end
         RX_START: begin
            if (clk_cnt == HALF_LAST) begin
               clk_cnt_next = '0;
               state_next   = rxd_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_next = '0;
               shift_next   = {rxd_sync, shift[7:1]};
               if (bit_idx == 3'd7) state_next = RX_STOP;
               else bit_idx_next = bit_idx + 3'd1;
            end
         end
         RX_STOP: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_next = '0;
               state_next   = RX_IDLE;
               valid_next   = rxd_sync;
               ferr_next    = !rxd_sync;
            end
         end
         default: state_next = RX_IDLE;
      endcase
   end

   assign data = shift;
   assign busy = (state != RX_IDLE);

endmodule

// File: rtl/uart_digit_receiver.sv
// Collects four ASCII digits from a UART stream into BCD outputs, flagging
// framing errors, non-digit bytes and stalled partial frames on err.
module uart_digit_receiver
   import uart_digit_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic       frame_valid,
   output logic       err
);

   localparam int TIMEOUT_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW = (TIMEOUT_LIMIT > 1) ? $clog2(TIMEOUT_LIMIT) : 1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_LIMIT - 1);

   logic [7:0]    rx_data;
   logic          byte_valid, frame_err, rx_busy;
   logic [1:0]    index;
   logic [3:0]    shadow [4];
   logic [TW-1:0] tcnt;
   logic          is_digit, timeout_hit, any_err, frame_done;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .data      (rx_data),
      .byte_valid(byte_valid),
      .frame_err (frame_err),
      .busy      (rx_busy)
   );

   // All error sources merge into one term so coincident causes give one pulse
   always_comb begin
      is_digit    = (rx_data >= ASCII_ZERO) && (rx_data <= ASCII_NINE);
      timeout_hit = !rx_busy && (index != 2'd0) && (tcnt == TIMEOUT_LAST) && !byte_valid;
      any_err     = frame_err || (byte_valid && !is_digit) || timeout_hit;
      frame_done  = byte_valid && is_digit && (index == 2'd3);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else if (rx_busy || (index == 2'd0) || timeout_hit) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // The fourth digit bypasses its shadow so all outputs change on one edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index       <= 2'd0;
         shadow      <= '{default: 4'd0};
         digit0      <= 4'd0;
         digit1      <= 4'd0;
         digit2      <= 4'd0;
         digit3      <= 4'd0;
         frame_valid <= 1'b0;
         err         <= 1'b0;
      end else begin
         frame_valid <= frame_done;
         err         <= any_err;
         if (any_err) begin
            index <= 2'd0;
         end else if (byte_valid && is_digit) begin
            shadow[index] <= rx_data[3:0];
            index         <= index + 2'd1;
            if (frame_done) begin
               digit0 <= shadow[0];
               digit1 <= shadow[1];
               digit2 <= shadow[2];
               digit3 <= rx_data[3:0];
            end
         end
      end
   end

endmodule
